// File: rtl/result_seq_pkg.sv
// Shared sizing and state encoding for the result-sequence buffer controller.
package result_seq_pkg;

   localparam int unsigned RS_DEPTH = 10;
   localparam int unsigned RS_WIDTH = 32;
   localparam int unsigned RS_IDX_W = 4;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/rise_detect.sv
// Registers the previous level of a signal and flags the cycle it first goes high.
module rise_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise_c
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   // Combinational so the write lands on the same edge that first samples the high level.
   assign rise_c = d & ~prev_q;

endmodule

// File: rtl/result_seq_ctrl.sv
// Result-sequence store: captures FSM results on wr_req rising edges and steps a wrapping display index.
module result_seq_ctrl
   import result_seq_pkg::*;
#(
   parameter int unsigned DEPTH = RS_DEPTH,
   parameter int unsigned WIDTH = RS_WIDTH,
   parameter int unsigned IDX_W = RS_IDX_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_req,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             nxt_stb,
   input  logic             clr_stb,
   output logic [WIDTH-1:0] rd_data,
   output logic [IDX_W-1:0] rd_idx,
   output logic [IDX_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             ovf
);

   localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);
   localparam logic [IDX_W-1:0] ONE_C   = IDX_W'(1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             ovf_q, ovf_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             wr_rise;
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;

   rise_detect u_wr_rise (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (wr_req),
      .rise_c  (wr_rise)
   );

   // Next-state: clear is applied first, then any same-cycle write lands on top of it.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_idx_d = rd_idx_q;
      ovf_d    = ovf_q;
      wr_en    = 1'b0;
      wr_addr  = count_q;

      if (clr_stb) begin
         state_d  = S_EMPTY;
         count_d  = '0;
         rd_idx_d = '0;
         ovf_d    = 1'b0;
      end else if (nxt_stb && (count_q != '0)) begin
         rd_idx_d = (rd_idx_q == (count_q - ONE_C)) ? '0 : (rd_idx_q + ONE_C);
      end

      if (wr_rise) begin
         if (clr_stb) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            count_d = ONE_C;
            state_d = (DEPTH_C == ONE_C) ? S_FULL : S_FILL;
         end else if (state_q == S_FULL) begin
            ovf_d = 1'b1;
         end else begin
            wr_en   = 1'b1;
            count_d = count_q + ONE_C;
            state_d = (count_d == DEPTH_C) ? S_FULL : S_FILL;
         end
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_EMPTY;
         count_q  <= '0;
         rd_idx_q <= '0;
         ovf_q    <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_idx_q <= rd_idx_d;
         ovf_q    <= ovf_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
         end
      end
   end

   // Stale entries survive a clear; masking on count hides them.
   assign rd_data = (count_q == '0) ? '0 : mem_q[rd_idx_q];
   assign rd_idx  = rd_idx_q;
   assign count   = count_q;
   assign empty   = empty_q;
   assign full    = full_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_result_seq_ctrl.sv
// Directed bench for result_seq_ctrl with hand-computed expectations.
module tb_result_seq_ctrl;

   logic        clk;
   logic        reset_n;
   logic        wr_req;
   logic [31:0] wr_data;
   logic        nxt_stb;
   logic        clr_stb;
   logic [31:0] rd_data;
   logic [3:0]  rd_idx;
   logic [3:0]  count;
   logic        empty;
   logic        full;
   logic        ovf;

   int unsigned n_checks;
   int unsigned n_errors;

   result_seq_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_req  (wr_req),
      .wr_data (wr_data),
      .nxt_stb (nxt_stb),
      .clr_stb (clr_stb),
      .rd_data (rd_data),
      .rd_idx  (rd_idx),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] data);
      wr_req  = 1'b1;
      wr_data = data;
      tick();
      wr_req  = 1'b0;
      tick();
   endtask

   task automatic do_next();
      nxt_stb = 1'b1;
      tick();
      nxt_stb = 1'b0;
   endtask

   task automatic do_clear();
      clr_stb = 1'b1;
      tick();
      clr_stb = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      wr_req   = 1'b0;
      wr_data  = '0;
      nxt_stb  = 1'b0;
      clr_stb  = 1'b0;
      tick();
      tick();

      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_idx", 32'(rd_idx), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      reset_n = 1'b1;
      tick();

      // Three writes then browse with wrap
      do_write(32'h11);
      do_write(32'h22);
      do_write(32'h33);
      chk("t1_count", 32'(count), 32'd3);
      chk("t1_rd_data0", rd_data, 32'h11);
      do_next();
      chk("t1_idx1", 32'(rd_idx), 32'd1);
      chk("t1_data1", rd_data, 32'h22);
      do_next();
      chk("t1_idx2", 32'(rd_idx), 32'd2);
      chk("t1_data2", rd_data, 32'h33);
      do_next();
      chk("t1_idx_wrap", 32'(rd_idx), 32'd0);
      chk("t1_data_wrap", rd_data, 32'h11);

      // Fill to capacity, overflow, then clear
      do_clear();
      for (int i = 0; i < 10; i++) do_write(32'h100 + 32'(i));
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_count10", 32'(count), 32'd10);
      chk("t2_ovf_pre", 32'(ovf), 32'd0);
      do_write(32'hDEAD);
      chk("t2_count_ovf", 32'(count), 32'd10);
      chk("t2_ovf", 32'(ovf), 32'd1);
      for (int i = 0; i < 9; i++) do_next();
      chk("t2_idx9", 32'(rd_idx), 32'd9);
      chk("t2_mem9", rd_data, 32'h109);
      do_next();
      chk("t2_idx_wrap10", 32'(rd_idx), 32'd0);
      chk("t2_ovf_sticky", 32'(ovf), 32'd1);
      do_clear();
      chk("t2_clr_count", 32'(count), 32'd0);
      chk("t2_clr_empty", 32'(empty), 32'd1);
      chk("t2_clr_full", 32'(full), 32'd0);
      chk("t2_clr_ovf", 32'(ovf), 32'd0);
      chk("t2_clr_rd_data", rd_data, 32'd0);

      // Held wr_req yields a single write
      wr_req  = 1'b1;
      wr_data = 32'h5;
      for (int i = 0; i < 20; i++) tick();
      wr_req = 1'b0;
      tick();
      chk("t3_count", 32'(count), 32'd1);
      chk("t3_rd_data", rd_data, 32'h5);

      // Clear and write on the same edge
      do_clear();
      for (int i = 0; i < 4; i++) do_write(32'hA0 + 32'(i));
      chk("t4_count4", 32'(count), 32'd4);
      do_next();
      clr_stb = 1'b1;
      wr_req  = 1'b1;
      wr_data = 32'h77;
      tick();
      clr_stb = 1'b0;
      wr_req  = 1'b0;
      tick();
      chk("t4_count", 32'(count), 32'd1);
      chk("t4_rd_idx", 32'(rd_idx), 32'd0);
      chk("t4_rd_data", rd_data, 32'h77);
      chk("t4_empty", 32'(empty), 32'd0);

      // Next on empty, then asynchronous reset mid-cycle
      do_clear();
      do_next();
      chk("t5_idx_empty", 32'(rd_idx), 32'd0);
      chk("t5_data_empty", rd_data, 32'd0);
      do_write(32'hB0);
      do_write(32'hB1);
      do_next();
      chk("t5_count2", 32'(count), 32'd2);
      chk("t5_idx1", 32'(rd_idx), 32'd1);
      #2;
      reset_n = 1'b0;
      wr_req  = 1'b1;
      wr_data = 32'hC0;
      #1;
      chk("t5_async_count", 32'(count), 32'd0);
      chk("t5_async_idx", 32'(rd_idx), 32'd0);
      chk("t5_async_data", rd_data, 32'd0);
      chk("t5_async_empty", 32'(empty), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("t5_post_rst_count", 32'(count), 32'd1);
      chk("t5_post_rst_data", rd_data, 32'hC0);
      tick();
      chk("t5_post_rst_hold", 32'(count), 32'd1);
      wr_req = 1'b0;
      tick();

      // Write and next together: wrap uses pre-write count
      do_clear();
      do_write(32'hD0);
      do_write(32'hD1);
      do_next();
      chk("t6_idx1", 32'(rd_idx), 32'd1);
      wr_req  = 1'b1;
      wr_data = 32'hD2;
      nxt_stb = 1'b1;
      tick();
      wr_req  = 1'b0;
      nxt_stb = 1'b0;
      tick();
      chk("t6_idx_wrap", 32'(rd_idx), 32'd0);
      chk("t6_count", 32'(count), 32'd3);
      do_next();
      do_next();
      chk("t6_idx2", 32'(rd_idx), 32'd2);
      chk("t6_data2", rd_data, 32'hD2);

      // Clear beats next
      clr_stb = 1'b1;
      nxt_stb = 1'b1;
      tick();
      clr_stb = 1'b0;
      nxt_stb = 1'b0;
      chk("t7_idx", 32'(rd_idx), 32'd0);
      chk("t7_count", 32'(count), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
